// File: rtl/bno085_pkg.sv
// Shared constants, FSM state type and report-length lookup
// for the BNO085 SHTP report parser.
package bno085_pkg;

    localparam int SHTP_HDR_LEN = 4;
    localparam int STAGE_BYTES  = 14;

    localparam logic [7:0] RPT_ROT_VEC  = 8'h05;
    localparam logic [7:0] RPT_GYRO_CAL = 8'h02;
    localparam logic [7:0] RPT_TIMEBASE = 8'hFB;
    localparam logic [7:0] RPT_REBASE   = 8'hFA;

    localparam logic [3:0] LEN_ROT_VEC  = 4'd14;
    localparam logic [3:0] LEN_GYRO_CAL = 4'd10;
    localparam logic [3:0] LEN_TIMEBASE = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RPT_ID,
        ST_BODY,
        ST_SKIP,
        ST_DONE
    } state_t;

    // Zero marks an ID this parser cannot size.
    function automatic logic [3:0] rpt_len(input logic [7:0] id);
        logic [3:0] len;
        case (id)
            RPT_ROT_VEC:  len = LEN_ROT_VEC;
            RPT_GYRO_CAL: len = LEN_GYRO_CAL;
            RPT_TIMEBASE: len = LEN_TIMEBASE;
            RPT_REBASE:   len = LEN_TIMEBASE;
            default:      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/bno085_report_parser_if.sv
// Byte stream from the sensor-side SPI master into the parser.
// master drives the bytes, slave (the parser) consumes them.
interface bno085_report_parser_if;

    logic       rx_frame;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (
        output rx_frame,
        output rx_valid,
        output rx_byte
    );

    modport slave (
        input rx_frame,
        input rx_valid,
        input rx_byte
    );

endinterface

// File: rtl/bno085_report_parser.sv
// SHTP packet parser: extracts rotation-vector and calibrated-gyro
// reports from the BNO085 byte stream into held, atomically updated outputs.
module bno085_report_parser
    import bno085_pkg::*;
#(
    parameter int INPUT_CHANNEL = 3,
    parameter int MAX_PKT_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    bno085_report_parser_if.slave rx,
    output logic                  quat_valid,
    output logic [15:0]           quat_w,
    output logic [15:0]           quat_x,
    output logic [15:0]           quat_y,
    output logic [15:0]           quat_z,
    output logic                  gyro_valid,
    output logic [15:0]           gyro_x,
    output logic [15:0]           gyro_y,
    output logic [15:0]           gyro_z,
    output logic                  quat_update,
    output logic                  gyro_update,
    output logic                  pkt_error
);

    localparam logic [15:0] W_MAX_LEN  = 16'(MAX_PKT_LEN);
    localparam logic [7:0]  W_CHAN     = 8'(INPUT_CHANNEL);
    localparam logic [15:0] W_HDR_LAST = 16'(SHTP_HDR_LEN - 1);
    localparam logic [15:0] W_MIN_LEN  = 16'(SHTP_HDR_LEN + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0] r_cnt;
    logic [15:0] r_pkt_len;
    logic [7:0]  r_len_lsb;
    logic [7:0]  r_len_msb;
    logic [7:0]  r_chan;
    logic [7:0]  r_rpt_id;
    logic [3:0]  r_rpt_len;
    logic [3:0]  r_rpt_idx;

    logic [STAGE_BYTES-1:0][7:0] r_stage;
    logic [STAGE_BYTES-1:0][7:0] w_stage;

    logic        w_rx;
    logic [15:0] w_hdr_len;
    logic [15:0] w_pkt_len;
    logic [3:0]  w_id_len;
    logic [15:0] w_cnt_nxt;
    logic        w_fits;
    logic        w_rpt_last;
    logic        w_bad_hdr;
    logic        w_err;
    logic        w_commit_q;
    logic        w_commit_g;

    assign w_rx       = rx.rx_valid & rx.rx_frame;
    assign w_hdr_len  = {1'b0, r_len_msb[6:0], r_len_lsb};
    assign w_pkt_len  = (w_hdr_len > W_MAX_LEN) ? W_MAX_LEN : w_hdr_len;
    assign w_id_len   = rpt_len(rx.rx_byte);
    assign w_cnt_nxt  = r_cnt + 16'd1;
    assign w_fits     = (r_cnt + {12'd0, w_id_len}) <= r_pkt_len;
    assign w_rpt_last = (r_rpt_idx == (r_rpt_len - 4'd1));
    assign w_bad_hdr  = (w_hdr_len < W_MIN_LEN) || (r_chan != W_CHAN);

    // Staging image including the byte arriving this cycle, so a
    // commit can read the final byte without an extra cycle.
    always_comb begin
        w_stage = r_stage;
        if (r_state == ST_RPT_ID) begin
            w_stage[0] = rx.rx_byte;
        end else begin
            w_stage[r_rpt_idx] = rx.rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_commit_q  = 1'b0;
        w_commit_g  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rx) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!rx.rx_frame) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_rx && r_cnt == W_HDR_LAST) begin
                    w_state_nxt = w_bad_hdr ? ST_SKIP : ST_RPT_ID;
                end
            end
            ST_RPT_ID: begin
                if (!rx.rx_frame) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_rx) begin
                    if (w_id_len == 4'd0 || !w_fits) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_SKIP;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (!rx.rx_frame) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_rx && w_rpt_last) begin
                    w_commit_q  = (r_rpt_id == RPT_ROT_VEC);
                    w_commit_g  = (r_rpt_id == RPT_GYRO_CAL);
                    w_state_nxt = (w_cnt_nxt < r_pkt_len) ?
                                  ST_RPT_ID : ST_DONE;
                end
            end
            ST_SKIP, ST_DONE: begin
                if (!rx.rx_frame) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_pkt_len   <= '0;
            r_len_lsb   <= '0;
            r_len_msb   <= '0;
            r_chan      <= '0;
            r_rpt_id    <= '0;
            r_rpt_len   <= '0;
            r_rpt_idx   <= '0;
            r_stage     <= '0;
            quat_valid  <= 1'b0;
            quat_w      <= '0;
            quat_x      <= '0;
            quat_y      <= '0;
            quat_z      <= '0;
            gyro_valid  <= 1'b0;
            gyro_x      <= '0;
            gyro_y      <= '0;
            gyro_z      <= '0;
            quat_update <= 1'b0;
            gyro_update <= 1'b0;
            pkt_error   <= 1'b0;
        end else begin
            quat_update <= w_commit_q;
            gyro_update <= w_commit_g;
            pkt_error   <= w_err;

            if (w_rx) begin
                r_cnt <= (r_state == ST_IDLE) ? 16'd1 : w_cnt_nxt;
                unique case (r_state)
                    ST_IDLE: begin
                        r_len_lsb <= rx.rx_byte;
                    end
                    ST_HDR: begin
                        if (r_cnt == 16'd1) r_len_msb <= rx.rx_byte;
                        if (r_cnt == 16'd2) r_chan    <= rx.rx_byte;
                        if (r_cnt == W_HDR_LAST) r_pkt_len <= w_pkt_len;
                    end
                    ST_RPT_ID: begin
                        r_rpt_id  <= rx.rx_byte;
                        r_rpt_len <= w_id_len;
                        r_rpt_idx <= 4'd1;
                        r_stage   <= w_stage;
                    end
                    ST_BODY: begin
                        r_rpt_idx <= r_rpt_idx + 4'd1;
                        r_stage   <= w_stage;
                    end
                    default: begin
                    end
                endcase
            end

            if (w_commit_q) begin
                quat_valid <= 1'b1;
                quat_x     <= {w_stage[5],  w_stage[4]};
                quat_y     <= {w_stage[7],  w_stage[6]};
                quat_z     <= {w_stage[9],  w_stage[8]};
                quat_w     <= {w_stage[11], w_stage[10]};
            end

            if (w_commit_g) begin
                gyro_valid <= 1'b1;
                gyro_x     <= {w_stage[5], w_stage[4]};
                gyro_y     <= {w_stage[7], w_stage[6]};
                gyro_z     <= {w_stage[9], w_stage[8]};
            end
        end
    end

endmodule

// File: tb/tb_bno085_report_parser.sv
// Scoreboard bench for bno085_report_parser: directed SHTP packets,
// expected commits queued by stimulus, checked by an output monitor.
module tb_bno085_report_parser;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        quat_valid, gyro_valid;
    logic [15:0] quat_w, quat_x, quat_y, quat_z;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        quat_update, gyro_update, pkt_error;

    vec_t       q_quat[$];
    vec_t       q_gyro[$];
    int         err_pend = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] pkt[$];
    logic [63:0] pq, pg;

    always #5 clk = ~clk;

    bno085_report_parser_if rxif();

    bno085_report_parser dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rxif.slave),
        .quat_valid  (quat_valid),
        .quat_w      (quat_w),
        .quat_x      (quat_x),
        .quat_y      (quat_y),
        .quat_z      (quat_z),
        .gyro_valid  (gyro_valid),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .quat_update (quat_update),
        .gyro_update (gyro_update),
        .pkt_error   (pkt_error)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected commits on update pulses and flags any
    // output change that is not accompanied by its update pulse.
    always @(negedge clk) begin
        vec_t e;
        if (!rst) begin
            if (quat_update) begin
                if (q_quat.size() == 0) begin
                    chk("quat_update unexpected", {31'd0, quat_update}, 0);
                end else begin
                    e = q_quat.pop_front();
                    chk("quat_w", {16'd0, quat_w}, {16'd0, e.a});
                    chk("quat_x", {16'd0, quat_x}, {16'd0, e.b});
                    chk("quat_y", {16'd0, quat_y}, {16'd0, e.c});
                    chk("quat_z", {16'd0, quat_z}, {16'd0, e.d});
                    chk("quat_valid at update", {31'd0, quat_valid}, 1);
                end
            end else if ({quat_w, quat_x, quat_y, quat_z} != pq) begin
                chk("quat held w/x", {quat_w, quat_x}, pq[63:32]);
                chk("quat held y/z", {quat_y, quat_z}, pq[31:0]);
            end
            if (gyro_update) begin
                if (q_gyro.size() == 0) begin
                    chk("gyro_update unexpected", {31'd0, gyro_update}, 0);
                end else begin
                    e = q_gyro.pop_front();
                    chk("gyro_x", {16'd0, gyro_x}, {16'd0, e.a});
                    chk("gyro_y", {16'd0, gyro_y}, {16'd0, e.b});
                    chk("gyro_z", {16'd0, gyro_z}, {16'd0, e.c});
                    chk("gyro_valid at update", {31'd0, gyro_valid}, 1);
                end
            end else if ({gyro_x, gyro_y, gyro_z, 16'd0} != pg) begin
                chk("gyro held x/y", {gyro_x, gyro_y}, pg[63:32]);
                chk("gyro held z", {16'd0, gyro_z}, {16'd0, pg[31:16]});
            end
            if (pkt_error) begin
                if (err_pend == 0) begin
                    chk("pkt_error unexpected", {31'd0, pkt_error}, 0);
                end else begin
                    err_pend--;
                    chk("pkt_error expected", {31'd0, pkt_error}, 1);
                end
            end
        end
        pq = {quat_w, quat_x, quat_y, quat_z};
        pg = {gyro_x, gyro_y, gyro_z, 16'd0};
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxif.rx_valid = 1'b1;
        rxif.rx_byte  = b;
        @(negedge clk);
        rxif.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        @(negedge clk);
        rxif.rx_frame = 1'b1;
        for (int i = 0; i < n && i < pkt.size(); i++) send_byte(pkt[i]);
        @(negedge clk);
        rxif.rx_frame = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        rxif.rx_frame = 1'b0;
        rxif.rx_valid = 1'b0;
        rxif.rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset quat_valid", {31'd0, quat_valid}, 0);
        chk("reset gyro_valid", {31'd0, gyro_valid}, 0);
        chk("reset quat_w", {16'd0, quat_w}, 0);
        chk("reset gyro_z", {16'd0, gyro_z}, 0);
        chk("reset pkt_error", {31'd0, pkt_error}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Timebase then rotation vector in one packet.
        pkt = {8'h17, 8'h00, 8'h03, 8'h00,
               8'hFB, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'hBC, 8'h9A,
               8'hF0, 8'hDE, 8'h34, 8'h12, 8'h00, 8'h00};
        q_quat.push_back('{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});
        send_pkt(pkt.size());
        chk("p1 quat_valid", {31'd0, quat_valid}, 1);
        chk("p1 gyro_valid", {31'd0, gyro_valid}, 0);

        // Stray byte outside a frame must be ignored.
        send_byte(8'h17);
        // Gyro report followed by bytes past the declared length.
        pkt = {8'h0E, 8'h00, 8'h03, 8'h01,
               8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h05, 8'hAA, 8'hBB};
        q_gyro.push_back('{16'h1111, 16'h2222, 16'h3333, 16'h0000});
        send_pkt(pkt.size());
        chk("p2 gyro_valid", {31'd0, gyro_valid}, 1);
        chk("p2 quat_w held", {16'd0, quat_w}, 32'h1234);

        // Truncated quaternion packet, then a good one.
        pkt = {8'h17, 8'h00, 8'h03, 8'h02,
               8'hFB, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h00};
        err_pend++;
        send_pkt(12);
        chk("trunc quat_x held", {16'd0, quat_x}, 32'h5678);
        q_quat.push_back('{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF});
        send_pkt(pkt.size());

        // Foreign channel carrying a rotation-vector lookalike.
        pkt = {8'h17, 8'h00, 8'h02, 8'h00,
               8'hFB, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00};
        send_pkt(pkt.size());

        // Unknown report ID, then gyro with continuation bit set.
        pkt = {8'h0A, 8'h00, 8'h03, 8'h00,
               8'h7E, 8'h05, 8'h00, 8'h00, 8'h11, 8'h22};
        err_pend++;
        send_pkt(pkt.size());
        pkt = {8'h0E, 8'h80, 8'h03, 8'h02,
               8'h02, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'h01, 8'h80,
               8'h00, 8'h00};
        q_gyro.push_back('{16'hFFFE, 16'h8001, 16'h0000, 16'h0000});
        send_pkt(pkt.size());

        // Report overrunning the declared packet length.
        pkt = {8'h0C, 8'h00, 8'h03, 8'h00,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        err_pend++;
        send_pkt(pkt.size());

        // Header-only length: skipped silently.
        pkt = {8'h04, 8'h00, 8'h03, 8'h00,
               8'h05, 8'h01, 8'h02, 8'h03};
        send_pkt(pkt.size());
        chk("short quat_w held", {16'd0, quat_w}, 32'h7FFF);
        chk("short gyro_x held", {16'd0, gyro_x}, 32'hFFFE);

        // Reset in the middle of a rotation-vector body.
        pkt = {8'h17, 8'h00, 8'h03, 8'h00,
               8'hFB, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55};
        @(negedge clk);
        rxif.rx_frame = 1'b1;
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i]);
        rst           = 1'b1;
        rxif.rx_frame = 1'b0;
        @(negedge clk);
        chk("rst quat_valid", {31'd0, quat_valid}, 0);
        chk("rst gyro_valid", {31'd0, gyro_valid}, 0);
        chk("rst quat_w", {16'd0, quat_w}, 0);
        chk("rst quat_z", {16'd0, quat_z}, 0);
        chk("rst gyro_x", {16'd0, gyro_x}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Timebase, rotation vector and gyro in one packet.
        pkt = {8'h21, 8'h00, 8'h03, 8'h05,
               8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h23, 8'h01, 8'h67, 8'h45,
               8'hAB, 8'h89, 8'hBC, 8'h0A, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'hF0, 8'hF0,
               8'h5A, 8'h5A};
        q_quat.push_back('{16'h0ABC, 16'h0123, 16'h4567, 16'h89AB});
        q_gyro.push_back('{16'h0F0F, 16'hF0F0, 16'h5A5A, 16'h0000});
        send_pkt(pkt.size());

        repeat (10) @(negedge clk);
        chk("quat commits drained", q_quat.size(), 0);
        chk("gyro commits drained", q_gyro.size(), 0);
        chk("pkt_error drained", err_pend, 0);
        chk("final quat_valid", {31'd0, quat_valid}, 1);
        chk("final gyro_valid", {31'd0, gyro_valid}, 1);
        chk("final quat_w", {16'd0, quat_w}, 32'h0ABC);
        chk("final gyro_z", {16'd0, gyro_z}, 32'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
